nanci_row_drain: RTL
====================

Name: nanci_row_drain

Overview:
- Downstream consumer of one mesh row of PEs.
- When the host signals that sorting has finished, it snapshots the row's PE output words in one cycle.
- It then serializes the snapshot out through a valid/ready stream, one word per handshake, PE 0 first.
- While streaming, it checks that the data fields come out in nondecreasing order and flags any violation for the host/testbench.

Parameters:
- SQRT_N, 4: number of PEs in the row (>=1).
- ADDR_WIDTH, 3: address field width of a PE word.
- DATA_WIDTH, 3: data field width of a PE word.
- Derived, not overridable:
  - W = ADDR_WIDTH+DATA_WIDTH.
  - IDX_W = max(1, clog2(SQRT_N)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle request to snapshot and drain the row.
- i_row  in  W*SQRT_N  concatenated o_PE words; PE k at bits [k*W +: W].
- i_ready  in  1  downstream can accept o_word this cycle.
- o_valid  out  1  o_word/o_idx hold a valid word.
- o_word  out  W  PE word {addr[W-1:DATA_WIDTH], data[DATA_WIDTH-1:0]}.
- o_idx  out  IDX_W  source PE index of o_word.
- o_busy  out  1  drain in progress.
- o_done  out  1  one-cycle pulse after the last word transfers.
- o_order_err  out  1  sticky; a data field was less than its predecessor.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - All outputs 0: o_valid, o_word, o_idx, o_busy, o_done, o_order_err.
  - Snapshot register cleared.
  - Reset takes priority over every other event, including mid-drain; the drain is abandoned and no o_done is produced.
- States: IDLE, DRAIN.
- IDLE:
  - i_start=1 at edge t: capture i_row into the snapshot, clear o_order_err, clear the index, go to DRAIN.
  - From t+1: o_valid=1, o_busy=1, o_idx=0, o_word=snapshot word 0.
- DRAIN:
  - Handshake = o_valid & i_ready at an edge.
  - On a handshake with idx < SQRT_N-1: idx+1; o_word shows the next snapshot word in the next cycle.
  - On a handshake with idx = SQRT_N-1: go to IDLE; o_valid=0 and o_busy=0 next cycle; o_done=1 for exactly that one cycle.
  - No handshake: o_word, o_idx and o_valid hold stable. No word is skipped or duplicated.
- Throughput: one word per cycle while i_ready stays high, so SQRT_N cycles from first o_valid to the last handshake.
- Start handling:
  - i_start is ignored in DRAIN.
  - i_start is accepted in the o_done cycle, because the state is IDLE then.
- The snapshot is immune to i_row changes after capture.
- Order check:
  - On the handshake of word k>=1, compare the unsigned data fields. If data(k) < data(k-1), set o_order_err at that edge.
  - Equal values are legal.
  - The previous data value is taken from the snapshot, not from the output bus.
  - o_order_err stays set through o_done and IDLE; it is cleared only by rst or an accepted i_start.
- SQRT_N=1: one word at idx 0, o_done after its handshake, o_order_err never set.
- o_word and o_idx are 0 in IDLE.

Decomposition:
- Shared package nanci_pkg:
  - word-width and index-width constant functions;
  - field-extract helpers (addr/data slice of a W-bit word);
  - state encoding for IDLE/DRAIN.
- No sub-module required; snapshot mux, counter, FSM and order checker are inline.
- An optional nanci_order_check sub-module (prev-data register + comparator) is acceptable if reused elsewhere.

Test Plan (SQRT_N=4, ADDR_WIDTH=3, DATA_WIDTH=3):
1. Reset: rst=1 for 2 cycles, then rst=0 with no start -> all outputs 0 and stay 0.
2. Sorted drain: i_row = {011111, 010101, 001011, 000001} (PE3..PE0), pulse start, i_ready=1 ->
   - o_word 000001, 001011, 010101, 011111 on 4 consecutive cycles, o_idx 0..3;
   - o_done=1 for one cycle after the last word;
   - o_order_err=0.
3. Backpressure: same row, i_ready=0 for 3 cycles while o_idx=1 -> o_word held at 001011 with o_valid=1; then resumes at 010101, total 4 transfers.
4. Unsorted: PE0 word 000101, PE1 word 001011 (data 5 then 3) -> o_order_err=1 after the idx1 handshake; held through o_done; cleared on the next accepted start.
5. Stability: change i_row and pulse i_start during DRAIN -> output words match the original snapshot; no restart; one o_done.
6. Mid-drain reset: rst after the idx1 handshake -> next cycle o_valid=0, o_busy=0, no o_done; a subsequent start drains from idx 0 with fresh data.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared definitions for the NANCI mesh row drain: width helpers, PE word
// field extraction and the drain FSM state encoding.
package nanci_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    function automatic int word_width(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    // A one-PE row still needs a one-bit index port.
    function automatic int idx_width(input int sqrt_n);
        return (sqrt_n <= 1) ? 1 : $clog2(sqrt_n);
    endfunction

    // Field helpers operate on a zero-extended 64-bit view of a PE word.
    function automatic logic [63:0] data_field(input logic [63:0] word, input int data_width);
        return word & ((64'd1 << data_width) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_field(input logic [63:0] word, input int data_width);
        return word >> data_width;
    endfunction

endpackage

// File: rtl/nanci_row_drain.sv
// Snapshots one mesh row of PE words on request and streams them out over
// valid/ready, PE 0 first, flagging any decrease in the data fields.
module nanci_row_drain
    import nanci_pkg::*;
#(
    parameter  int SQRT_N     = 4,
    parameter  int ADDR_WIDTH = 3,
    parameter  int DATA_WIDTH = 3,
    localparam int W          = word_width(ADDR_WIDTH, DATA_WIDTH),
    localparam int IDX_W      = idx_width(SQRT_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [W*SQRT_N-1:0]   i_row,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [W-1:0]          o_word,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_order_err
);

    drain_state_t          state;
    logic [W-1:0]          snap [SQRT_N];
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [IDX_W-1:0]      prev_idx;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DATA_WIDTH-1:0] prev_data;
    logic                  handshake;
    logic                  last_word;
    logic                  order_drop;

    assign handshake = o_valid & i_ready;
    assign last_word = (idx == IDX_W'(SQRT_N - 1));
    assign idx_nxt   = idx + IDX_W'(1);
    assign o_idx     = idx;

    // The predecessor comes from the snapshot so a held or reset output bus
    // can never corrupt the comparison.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        prev_idx   = '0;
        cur_data   = '0;
        prev_data  = '0;
        order_drop = 1'b0;
        if (idx != '0) begin
            prev_idx = idx - IDX_W'(1);
        end
        cur_data   = DATA_WIDTH'(data_field(64'(snap[idx]), DATA_WIDTH));
        prev_data  = DATA_WIDTH'(data_field(64'(snap[prev_idx]), DATA_WIDTH));
        order_drop = (idx != '0) && (cur_data < prev_data);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            o_valid     <= 1'b0;
            o_word      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_order_err <= 1'b0;
            // NOTE: the snapshot is a small register file, so clearing it on reset is cheap and deterministic.
            for (int k = 0; k < SQRT_N; k++) begin
                snap[k] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        for (int k = 0; k < SQRT_N; k++) begin
                            snap[k] <= i_row[k*W +: W];
                        end
                        idx         <= '0;
                        o_word      <= i_row[0 +: W];
                        o_valid     <= 1'b1;
                        o_busy      <= 1'b1;
                        o_order_err <= 1'b0;
                        state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (handshake) begin
                        if (order_drop) begin
                            o_order_err <= 1'b1;
                        end
                        if (last_word) begin
                            idx     <= '0;
                            o_word  <= '0;
                            o_valid <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            idx    <= idx_nxt;
                            o_word <= snap[idx_nxt];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
